// File: rtl/palette_quantizer_pkg.sv
// Shared types and constants for the palette quantizer.
//   rgb12_t         : packed {r,g,b}, 4 bits per channel
//   palette_t       : 16 rgb12_t entries, entry 0 leftmost
//   PALETTE_DEFAULT : sprite palette used unless overridden
//   state_t         : search FSM states
package palette_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef rgb12_t [0:15] palette_t;

  localparam int DIST_W = 6;
  localparam logic [DIST_W-1:0] DIST_MAX = 6'd63;

  localparam palette_t PALETTE_DEFAULT = {
    12'h724, 12'hF0D, 12'hABC, 12'h447,
    12'h223, 12'hB35, 12'h779, 12'h435,
    12'h667, 12'h524, 12'h546, 12'h445,
    12'hBCD, 12'h313, 12'h734, 12'h99A
  };

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

endpackage

// File: rtl/palette_quantizer_rgb_distance.sv
// Combinational Manhattan distance between two 12-bit colours.
//   i_a, i_b : colours to compare
//   o_dist   : |dR|+|dG|+|dB|, 0..45
module rgb_distance
  import palette_pkg::*;
(
  input  rgb12_t            i_a,
  input  rgb12_t            i_b,
  output logic [DIST_W-1:0] o_dist
);

  function automatic logic [3:0] absdiff(input logic [3:0] x, input logic [3:0] y);
    return (x > y) ? (x - y) : (y - x);
  endfunction

  logic [3:0] w_dr, w_dg, w_db;

  always_comb begin
    w_dr   = absdiff(i_a.r, i_b.r);
    w_dg   = absdiff(i_a.g, i_b.g);
    w_db   = absdiff(i_a.b, i_b.b);
    // Three 4-bit terms max out at 45, so 6 bits never overflow.
    o_dist = {2'b00, w_dr} + {2'b00, w_dg} + {2'b00, w_db};
  end

endmodule

// File: rtl/palette_quantizer.sv
// Nearest-palette-entry search: one entry evaluated per cycle.
//   clk, reset_n          : clock, synchronous active-low reset
//   in_valid/in_ready     : colour input handshake, in_rgb {R,G,B}
//   out_valid/out_ready   : result handshake
//   out_index, out_dist   : nearest entry and its Manhattan distance
module palette_quantizer
  import palette_pkg::*;
#(
  parameter palette_t PALETTE    = PALETTE_DEFAULT,
  parameter bit       EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_rgb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_index,
  output logic [5:0]  out_dist
);

  state_t            r_state, w_next;
  rgb12_t            r_rgb;
  logic [3:0]        r_k;
  logic [3:0]        r_best_idx;
  logic [DIST_W-1:0] r_best_dist;
  logic [3:0]        r_out_index;
  logic [DIST_W-1:0] r_out_dist;

  logic [DIST_W-1:0] w_dist;
  logic              w_better;
  logic [3:0]        w_cand_idx;
  logic [DIST_W-1:0] w_cand_dist;
  logic              w_last;

  rgb_distance u_dist (
    .i_a    (r_rgb),
    .i_b    (PALETTE[r_k]),
    .o_dist (w_dist)
  );

  // Strict compare keeps the lower index on ties.
  always_comb begin
    w_better    = (w_dist < r_best_dist);
    w_cand_idx  = w_better ? r_k    : r_best_idx;
    w_cand_dist = w_better ? w_dist : r_best_dist;
    // Forced exit at k==15 means the counter never wraps back to entry 0.
    w_last      = (EARLY_EXIT && (w_dist == '0)) || (r_k == 4'd15);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = SEARCH;
      SEARCH:  if (w_last)   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    out_index = r_out_index;
    out_dist  = r_out_dist;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rgb       <= '0;
      r_k         <= '0;
      r_best_idx  <= '0;
      r_best_dist <= '0;
      r_out_index <= '0;
      r_out_dist  <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_rgb       <= rgb12_t'(in_rgb);
          r_k         <= '0;
          r_best_idx  <= '0;
          r_best_dist <= DIST_MAX;
        end
        SEARCH: begin
          r_best_idx  <= w_cand_idx;
          r_best_dist <= w_cand_dist;
          if (w_last) begin
            // Result registers hold steady for the whole DONE stall.
            r_out_index <= w_cand_idx;
            r_out_dist  <= w_cand_dist;
          end else begin
            r_k <= r_k + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/palette_quantizer.md
Name: palette_quantizer

Overview:
- Reverse of the sprite palette lookup: takes a 12-bit RGB colour (4 bits per channel) and returns the 4-bit index of the nearest entry in a 16-entry palette.
- Used when converting captured or generated colours (e.g. dynamically tinted tank/battery sprites) back into palette-index form for sprite RAM writes.
- Sequential search: one palette entry per cycle, valid/ready handshake on input and output.

Parameters:
- PALETTE, palette_pkg::PALETTE_DEFAULT, 16 x 12-bit packed palette ({R,G,B} per entry, entry 0 first).
- EARLY_EXIT, 1, when 1 the search terminates on an exact match (distance 0).

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous reset, active-low
- in_valid  input  1  in_rgb is valid
- in_ready  output  1  block can accept a colour
- in_rgb  input  12  {red[3:0], green[3:0], blue[3:0]}
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_index  output  4  nearest palette index
- out_dist  output  6  Manhattan distance of the match (0..45)

Behaviour:
- One clock; reset is synchronous and active-low (reset_n sampled on rising clk).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_index=0, out_dist=0, internal counter/best registers 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_rgb, clear counter k=0, set best_dist=63 → SEARCH.
  - SEARCH: in_ready=0. Each cycle evaluates entry k.
    - d = |dR|+|dG|+|dB|; each channel difference is an unsigned 4-bit absolute value; sum is 6 bits and cannot overflow.
    - If d < best_dist (strict), update best_idx=k and best_dist=d. Ties keep the lower index.
    - If EARLY_EXIT and d==0, or k==15 → DONE (using the updated best). Otherwise k++.
  - DONE: out_valid=1, out_index/out_dist are registered best values, stable while out_valid && !out_ready. On out_ready → IDLE.
- Latency, with input accepted in cycle T:
  - Entry k is evaluated in cycle T+1+k.
  - Full search: out_valid first high in cycle T+17.
  - Exact match at entry k with EARLY_EXIT=1: out_valid first high in cycle T+2+k.
- Throughput: after the output handshake in cycle U, in_ready=1 in cycle U+1. No overlap of searches.
- in_rgb changes while not accepted are ignored; only the value latched at acceptance is used.
- reset_n low in any state, including mid-SEARCH or DONE with out_ready low: next cycle is IDLE, out_valid=0, the pending result is discarded.
- in_valid asserted during SEARCH/DONE is not accepted (in_ready=0); the upstream holds it.
- Counter k is 4 bits; the transition is forced at k==15, so no wrap-around ever reaches entry 0 again.

Decomposition:
- palette_pkg:
  - typedef rgb12_t (packed struct r,g,b of 4 bits each)
  - typedef palette_t ([0:15] rgb12_t)
  - PALETTE_DEFAULT constant (entry 0=0x724, 1=0xF0D, 2=0xABC, 3=0x447, 4=0x223, 5=0xB35, 6=0x779, 7=0x435, 8=0x667, 9=0x524, 10=0x546, 11=0x445, 12=0xBCD, 13=0x313, 14=0x734, 15=0x99A)
  - state enum {IDLE, SEARCH, DONE}
- Sub-module rgb_distance: combinational, two rgb12_t in → 6-bit Manhattan distance out. Unit-testable alone.

Test Plan:
- Reset then in_rgb=0x724, in_valid pulse at T, out_ready=1 → out_valid first high at T+2; index=0, dist=0; in_ready high at T+3.
- in_rgb=0xF0D, EARLY_EXIT=1 → index=1, dist=0, out_valid at T+3. Same stimulus with EARLY_EXIT=0 → same result, out_valid at T+17.
- in_rgb=0x000 → entries 4 (0x223) and 13 (0x313) both have dist 7. Required: index=4, dist=7 (tie to lower index), out_valid at T+17.
- in_rgb=0xFFF with out_ready held low 10 cycles → index=12, dist=9; out_valid, index and dist stable through the stall; in_ready=0 throughout; handshake completes on the first out_ready cycle.
- Accept 0x000, drive reset_n low at T+8 for one cycle → next cycle out_valid=0, in_ready=1; a following 0x99A search gives index=15, dist=0.
- Back-to-back: in_valid held high with 0x447 then 0x546 → two results (index 3, then 10, both dist 0), second accepted the cycle after the first output handshake.
